rob_multi_wb: RTL and testbench
===============================

// Module: rob_multi_wb
// PURPOSE
//  Parametrised reorder buffer. Sits between the decoder/issue stage and the register file.
//  Accepts one instruction per cycle and absorbs NUM_WB write-back channels per cycle (RS ALUs, LSB).
//  Retires in program order and resolves branch prediction at commit.
//  On a mispredict it raises a flush with the corrected PC.
// PARAMETERS
//  DEPTH   16  entries; power of two, >= 2
//  IDX_W   4   entry-index width; must equal log2(DEPTH)
//  NUM_WB  2   number of write-back channels; channel NUM_WB-1 has highest priority
// PORTS
//  clk               in   1           clock, rising edge
//  rst_n             in   1           asynchronous reset, active low
//  rdy               in   1           global enable; low freezes all state
//  rob_full          out  1           count == DEPTH
//  issue_valid       in   1           decoder presents an instruction
//  issue_type        in   7           instruction class (shared type codes)
//  issue_rd          in   5           destination register
//  issue_pc          in   32          instruction address
//  issue_imm         in   32          decoded immediate
//  issue_pred_taken  in   1           predictor's direction for B_TYPE
//  issue_rob_id      out  IDX_W       tail index; valid id for the instruction being issued
//  wb_valid          in   NUM_WB      per-channel result strobe
//  wb_rob_id         in   NUM_WB*IDX_W  flattened target entry ids
//  wb_value          in   NUM_WB*32   flattened results; for B_TYPE, bit0 = actual taken
//  wb_target         in   NUM_WB*32   flattened branch-taken target (B_TYPE only)
//  head_rob_id       out  IDX_W       oldest entry id (to LSB for store release)
//  commit_valid      out  1           head retires this cycle
//  commit_rob_id     out  IDX_W       retiring entry id
//  commit_rd         out  5           retiring destination register
//  commit_value      out  32          retiring value
//  commit_wr         out  1           register write required
//  flush             out  1           mispredicted branch retires this cycle
//  flush_pc          out  32          corrected fetch PC
//  q_id1, q_id2      in   IDX_W       operand lookup ids
//  q_ready1, q_ready2  out  1         value available
//  q_value1, q_value2  out  32        value
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - head=tail=count=0; all busy/prepared=0.
//   - All outputs 0, except issue_rob_id/head_rob_id=0.
//  Issue:
//   - Accepted when issue_valid & !rob_full & rdy & !flush; entry written at tail, tail+1 mod DEPTH.
//   - LUI/AUIPC/JAL/JALR are prepared at issue with value imm, pc+imm, pc+4, pc+4 respectively.
//   - All other types enter unprepared with value 0.
//   - issue_valid while full is ignored; the decoder must hold the instruction.
//  Write-back:
//   - For each channel with wb_valid and the target entry busy: prepared<=1; value and target stored.
//   - Write-back to a non-busy entry is ignored.
//   - Same id on two channels in one cycle: highest channel index wins.
//  Commit (combinational from head state, gated by rdy):
//   - commit_valid = busy[head] & prepared[head].
//   - commit_wr = commit_valid & type not B_TYPE/S_TYPE & rd != 0.
//   - The next edge clears the head entry and advances head by 1 mod DEPTH.
//   - Issue and commit in the same cycle leave count unchanged; count is 0..DEPTH.
//  Flush:
//   - Asserted when the committing entry is B_TYPE and value[0] != pred_taken.
//   - flush_pc = value[0] ? target : pc+4.
//   - On that edge all entries are cleared and head=tail=count=0.
//   - Same-cycle issue and write-backs are dropped. commit_valid stays 1 for the branch itself.
//  rdy=0: no state changes; commit_valid=0 and flush=0.
//  Wrap-around: indices wrap mod DEPTH. Full/empty are decided by count, never by head==tail.
// CONFIGURATION
//  ROB_WB_BYPASS_EN defined:
//   - q_readyN = prepared[q_idN] | any channel c with wb_valid[c] & wb_rob_id[c]==q_idN
//     | (accepted issue of a prepared-at-issue type & q_idN==tail).
//   - q_valueN priority: stored > highest matching channel > issue value.
//  ROB_WB_BYPASS_EN undefined:
//   - q_readyN = prepared[q_idN]; q_valueN = value[q_idN].
//   - Operands become visible one cycle after write-back.
// STRUCTURE
//  Shared package/header: instruction-type codes (LUI, AUIPC, JAL, JALR, B_TYPE, S_TYPE), ROB_DEPTH/IDX_W
//  defaults, flattened-slice helper macro.
//  One sub-module: rob_wb_match (NUM_WB-way id compare + priority mux), instantiated once per query port.
// TESTING
//  1. Reset mid-run: 5 entries live, pulse rst_n low -> all outputs 0 immediately, count 0.
//  2. Fill: 16 issues, no wb -> rob_full=1 after 16th; 17th ignored, tail stays 0 after wrap.
//  3. Out-of-order wb: ids 2,0,1 complete -> commits appear in order 0,1,2, one per cycle.
//  4. Dual wb, same cycle: ch0 id3=0x11, ch1 id3=0x22 -> value[3]=0x22.
//     Distinct ids both prepared after one edge.
//  5. Mispredict: B_TYPE pc=0x100, pred_taken=0, wb value=1, target=0x80 -> flush=1, flush_pc=0x80.
//     Next cycle count=0; same-cycle issue dropped.
//  6. Bypass (macro on): wb ch1 id5=0x7 while q_id1=5 -> q_ready1=1, q_value1=0x7 same cycle.
//     Macro off -> q_ready1=0 that cycle, 1 the next.

Source files
------------

// File: rtl/rob_multi_wb_pkg.sv
// Shared definitions for the reorder buffer: instruction-type codes, default sizes,
// entry metadata and the flattened-bus slice macro ROB_SLICE.
`ifndef ROB_MULTI_WB_PKG_SV
`define ROB_MULTI_WB_PKG_SV

`define ROB_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package rob_multi_wb_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = 4;

  localparam logic [6:0] TY_LUI    = 7'b0110111;
  localparam logic [6:0] TY_AUIPC  = 7'b0010111;
  localparam logic [6:0] TY_JAL    = 7'b1101111;
  localparam logic [6:0] TY_JALR   = 7'b1100111;
  localparam logic [6:0] TY_B_TYPE = 7'b1100011;
  localparam logic [6:0] TY_S_TYPE = 7'b0100011;

  typedef struct packed {
    logic [6:0]  itype;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] target;
  } rob_meta_t;

  // Link and upper-immediate instructions have their result known at decode.
  function automatic logic prepared_at_issue(input logic [6:0] itype);
    return (itype == TY_LUI) || (itype == TY_AUIPC) || (itype == TY_JAL) || (itype == TY_JALR);
  endfunction

  function automatic logic [31:0] issue_value(input logic [6:0] itype, input logic [31:0] pc,
                                              input logic [31:0] imm);
    logic [31:0] v;
    v = '0;
    if (itype == TY_LUI)        v = imm;
    else if (itype == TY_AUIPC) v = pc + imm;
    else if (itype == TY_JAL || itype == TY_JALR) v = pc + 32'd4;
    return v;
  endfunction

  // Operand forwarding priority: stored result, then write-back bus, then issuing instruction.
  function automatic logic [32:0] bypass_pick(input logic stored_rdy, input logic [31:0] stored_val,
                                              input logic wb_hit, input logic [31:0] wb_val,
                                              input logic iss_hit, input logic [31:0] iss_val);
    if (stored_rdy) return {1'b1, stored_val};
    if (wb_hit)     return {1'b1, wb_val};
    if (iss_hit)    return {1'b1, iss_val};
    return {1'b0, stored_val};
  endfunction

endpackage

`endif

// File: rtl/rob_multi_wb_match.sv
// Compares one operand-lookup id against all write-back channels; the highest
// matching channel index supplies the forwarded value.
module rob_wb_match #(
  parameter int NUM_WB = 2,
  parameter int IDX_W  = 4
) (
  input  logic [IDX_W-1:0]        q_id,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] wb_rob_id,
  input  logic [NUM_WB*32-1:0]    wb_value,
  output logic                    hit,
  output logic [31:0]             hit_value
);

  always_comb begin
    hit       = 1'b0;
    hit_value = '0;
    for (int c = 0; c < NUM_WB; c++) begin
      if (wb_valid[c] && (`ROB_SLICE(wb_rob_id, c, IDX_W) == q_id)) begin
        hit       = 1'b1;
        hit_value = `ROB_SLICE(wb_value, c, 32);
      end
    end
  end

endmodule

// File: rtl/rob_multi_wb.sv
// Reorder buffer with NUM_WB write-back channels, in-order commit and branch resolution at commit.
// Define ROB_WB_BYPASS_EN to forward same-cycle write-backs and issues to the operand lookups.
module rob_multi_wb
  import rob_multi_wb_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int IDX_W  = ROB_IDX_W,
  parameter int NUM_WB = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  output logic                    rob_full,
  input  logic                    issue_valid,
  input  logic [6:0]              issue_type,
  input  logic [4:0]              issue_rd,
  input  logic [31:0]             issue_pc,
  input  logic [31:0]             issue_imm,
  input  logic                    issue_pred_taken,
  output logic [IDX_W-1:0]        issue_rob_id,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] wb_rob_id,
  input  logic [NUM_WB*32-1:0]    wb_value,
  input  logic [NUM_WB*32-1:0]    wb_target,
  output logic [IDX_W-1:0]        head_rob_id,
  output logic                    commit_valid,
  output logic [IDX_W-1:0]        commit_rob_id,
  output logic [4:0]              commit_rd,
  output logic [31:0]             commit_value,
  output logic                    commit_wr,
  output logic                    flush,
  output logic [31:0]             flush_pc,
  input  logic [IDX_W-1:0]        q_id1,
  input  logic [IDX_W-1:0]        q_id2,
  output logic                    q_ready1,
  output logic                    q_ready2,
  output logic [31:0]             q_value1,
  output logic [31:0]             q_value2
);

  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] prepared;
  rob_meta_t        meta  [DEPTH];
  logic [31:0]      value [DEPTH];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;

  rob_meta_t head_meta;
  logic      issue_acc;
  logic      head_is_branch;

  assign head_meta      = meta[head];
  assign head_is_branch = (head_meta.itype == TY_B_TYPE);
  assign rob_full       = (count == FULL_COUNT);
  assign issue_rob_id   = tail;
  assign head_rob_id    = head;

  assign commit_valid  = rdy & busy[head] & prepared[head];
  assign commit_rob_id = head;
  assign commit_rd     = head_meta.rd;
  assign commit_value  = value[head];
  assign commit_wr     = commit_valid & ~head_is_branch & (head_meta.itype != TY_S_TYPE)
                         & (head_meta.rd != 5'd0);
  assign flush         = commit_valid & head_is_branch & (value[head][0] != head_meta.pred_taken);
  assign flush_pc      = !flush ? 32'd0 :
                         value[head][0] ? head_meta.target : head_meta.pc + 32'd4;

  assign issue_acc = issue_valid & ~rob_full & rdy & ~flush;

  // Within one cycle: issue fills tail, write-backs land, then commit clears head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      prepared <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        meta[i]  <= '0;
        value[i] <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        busy     <= '0;
        prepared <= '0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          meta[i]  <= '0;
          value[i] <= '0;
        end
      end else begin
        if (issue_acc) begin
          busy[tail]     <= 1'b1;
          prepared[tail] <= prepared_at_issue(issue_type);
          value[tail]    <= issue_value(issue_type, issue_pc, issue_imm);
          meta[tail]     <= '{itype: issue_type, rd: issue_rd, pc: issue_pc,
                              pred_taken: issue_pred_taken, target: 32'd0};
          tail           <= tail + 1'b1;
        end
        for (int c = 0; c < NUM_WB; c++) begin
          if (wb_valid[c] && busy[`ROB_SLICE(wb_rob_id, c, IDX_W)]) begin
            prepared[`ROB_SLICE(wb_rob_id, c, IDX_W)]    <= 1'b1;
            value[`ROB_SLICE(wb_rob_id, c, IDX_W)]       <= `ROB_SLICE(wb_value, c, 32);
            meta[`ROB_SLICE(wb_rob_id, c, IDX_W)].target <= `ROB_SLICE(wb_target, c, 32);
          end
        end
        if (commit_valid) begin
          busy[head]     <= 1'b0;
          prepared[head] <= 1'b0;
          value[head]    <= '0;
          head           <= head + 1'b1;
        end
        count <= count + {{IDX_W{1'b0}}, issue_acc} - {{IDX_W{1'b0}}, commit_valid};
      end
    end
  end

  logic        hit1, hit2;
  logic [31:0] hit_value1, hit_value2;

  rob_wb_match #(.NUM_WB(NUM_WB), .IDX_W(IDX_W)) u_match1 (
    .q_id(q_id1), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .hit(hit1), .hit_value(hit_value1)
  );

  rob_wb_match #(.NUM_WB(NUM_WB), .IDX_W(IDX_W)) u_match2 (
    .q_id(q_id2), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .hit(hit2), .hit_value(hit_value2)
  );

`ifdef ROB_WB_BYPASS_EN
  logic        issue_fwd;
  logic [31:0] issue_fwd_value;

  assign issue_fwd       = issue_acc & prepared_at_issue(issue_type);
  assign issue_fwd_value = issue_value(issue_type, issue_pc, issue_imm);

  assign {q_ready1, q_value1} = bypass_pick(prepared[q_id1], value[q_id1], hit1, hit_value1,
                                            issue_fwd & (q_id1 == tail), issue_fwd_value);
  assign {q_ready2, q_value2} = bypass_pick(prepared[q_id2], value[q_id2], hit2, hit_value2,
                                            issue_fwd & (q_id2 == tail), issue_fwd_value);
`else
  // Without forwarding, results become visible one cycle after write-back.
  logic unused_bypass;
  assign unused_bypass = ^{hit1, hit2, hit_value1, hit_value2};

  assign q_ready1 = prepared[q_id1];
  assign q_value1 = value[q_id1];
  assign q_ready2 = prepared[q_id2];
  assign q_value2 = value[q_id2];
`endif

endmodule

// File: tb/tb_rob_multi_wb.sv
// Self-checking bench for rob_multi_wb: directed scenarios plus randomized traffic checked
// against a program-order queue model; a separate monitor scores commits as they appear.
module tb_rob_multi_wb;
  import rob_multi_wb_pkg::*;

  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int NUM_WB = 2;
  localparam logic [6:0] TY_ALU = 7'b0110011;

  logic clk, rst_n, rdy, rob_full, issue_valid, issue_pred_taken;
  logic [6:0] issue_type;
  logic [4:0] issue_rd, commit_rd;
  logic [31:0] issue_pc, issue_imm, commit_value, flush_pc, q_value1, q_value2;
  logic [IDX_W-1:0] issue_rob_id, head_rob_id, commit_rob_id, q_id1, q_id2;
  logic [NUM_WB-1:0] wb_valid;
  logic [NUM_WB*IDX_W-1:0] wb_rob_id;
  logic [NUM_WB*32-1:0] wb_value, wb_target;
  logic commit_valid, commit_wr, flush, q_ready1, q_ready2;

  rob_multi_wb #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rob_full(rob_full),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_pred_taken(issue_pred_taken),
    .issue_rob_id(issue_rob_id), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id),
    .wb_value(wb_value), .wb_target(wb_target), .head_rob_id(head_rob_id),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_wr(commit_wr), .flush(flush), .flush_pc(flush_pc),
    .q_id1(q_id1), .q_id2(q_id2), .q_ready1(q_ready1), .q_ready2(q_ready2),
    .q_value1(q_value1), .q_value2(q_value2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [6:0]  ty;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pt;
    logic        done;
    logic [31:0] val;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    int          cyc;
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        wr;
    logic        fl;
    logic [31:0] fpc;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  int   next_id = 0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        s_rdy, s_iv, s_pt;
  logic [6:0]  s_ty;
  logic [4:0]  s_rd;
  logic [31:0] s_pc, s_imm;
  logic [1:0]  s_wv;
  logic [3:0]  s_wid [2];
  logic [31:0] s_wval [2];
  logic [31:0] s_wtgt [2];
  logic [3:0]  s_q [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic model_prep(input logic [6:0] t);
    return t == TY_LUI || t == TY_AUIPC || t == TY_JAL || t == TY_JALR;
  endfunction

  function automatic logic [31:0] model_value(input logic [6:0] t, input logic [31:0] pc,
                                              input logic [31:0] imm);
    case (t)
      TY_LUI:         return imm;
      TY_AUIPC:       return pc + imm;
      TY_JAL, TY_JALR: return pc + 32'd4;
      default:        return 32'd0;
    endcase
  endfunction

  function automatic int find_id(input logic [3:0] id);
    for (int i = 0; i < mq.size(); i++) if (mq[i].id == id) return i;
    return -1;
  endfunction

  task automatic idle_stim();
    s_rdy = 1'b1; s_iv = 1'b0; s_ty = TY_ALU; s_rd = '0; s_pc = '0; s_imm = '0; s_pt = 1'b0;
    s_wv = '0;
    for (int c = 0; c < 2; c++) begin s_wid[c] = '0; s_wval[c] = '0; s_wtgt[c] = '0; s_q[c] = '0; end
  endtask

  task automatic set_issue(input logic [6:0] t, input logic [4:0] rd, input logic [31:0] pc,
                           input logic [31:0] imm, input logic pt);
    s_iv = 1'b1; s_ty = t; s_rd = rd; s_pc = pc; s_imm = imm; s_pt = pt;
  endtask

  task automatic set_wb(input int c, input logic [3:0] id, input logic [31:0] v, input logic [31:0] tg);
    s_wv[c] = 1'b1; s_wid[c] = id; s_wval[c] = v; s_wtgt[c] = tg;
  endtask

  task automatic checkOutput(input logic full, input logic fl, input logic iss_ok);
    logic [3:0]  exp_head;
    logic        erdy, srdy, hit;
    logic [31:0] eval, hv;
    int          idx;
    exp_head = 4'(next_id - mq.size());
    check("rob_full", {31'd0, rob_full}, {31'd0, full});
    check("issue_rob_id", {28'd0, issue_rob_id}, next_id);
    check("head_rob_id", {28'd0, head_rob_id}, {28'd0, exp_head});
    check("flush", {31'd0, flush}, {31'd0, fl});
    for (int p = 0; p < 2; p++) begin
      idx  = find_id(s_q[p]);
      srdy = (idx >= 0) && mq[idx].done;
      eval = srdy ? mq[idx].val : 32'd0;
      erdy = srdy;
      hit = 1'b0; hv = '0;
      for (int c = 0; c < 2; c++) if (s_wv[c] && s_wid[c] == s_q[p]) begin hit = 1'b1; hv = s_wval[c]; end
`ifdef ROB_WB_BYPASS_EN
      if (!srdy && hit) begin erdy = 1'b1; eval = hv; end
      else if (!srdy && iss_ok && model_prep(s_ty) && s_q[p] == 4'(next_id)) begin
        erdy = 1'b1; eval = model_value(s_ty, s_pc, s_imm);
      end
`else
      if (hit && iss_ok) hv = '0;
`endif
      check(p == 0 ? "q_ready1" : "q_ready2", {31'd0, (p == 0 ? q_ready1 : q_ready2)}, {31'd0, erdy});
      if (erdy) check(p == 0 ? "q_value1" : "q_value2", (p == 0 ? q_value1 : q_value2), eval);
    end
  endtask

  task automatic applyStimulus();
    logic full, commit, fl, iss_ok;
    exp_t e;
    ent_t n;
    int   idx;
    @(posedge clk);
    cyc++;
    #1;
    rdy = s_rdy; issue_valid = s_iv; issue_type = s_ty; issue_rd = s_rd; issue_pc = s_pc;
    issue_imm = s_imm; issue_pred_taken = s_pt; wb_valid = s_wv;
    wb_rob_id = {s_wid[1], s_wid[0]}; wb_value = {s_wval[1], s_wval[0]};
    wb_target = {s_wtgt[1], s_wtgt[0]}; q_id1 = s_q[0]; q_id2 = s_q[1];
    full   = (mq.size() == DEPTH);
    commit = s_rdy && mq.size() > 0 && mq[0].done;
    fl     = commit && mq[0].ty == TY_B_TYPE && (mq[0].val[0] != mq[0].pt);
    iss_ok = s_iv && !full && s_rdy && !fl;
    if (commit) begin
      e.cyc = cyc; e.id = mq[0].id; e.rd = mq[0].rd; e.val = mq[0].val;
      e.wr  = mq[0].ty != TY_B_TYPE && mq[0].ty != TY_S_TYPE && mq[0].rd != 5'd0;
      e.fl  = fl;
      e.fpc = mq[0].val[0] ? mq[0].tgt : mq[0].pc + 32'd4;
      sb.push_back(e);
    end
    #1;
    checkOutput(full, fl, iss_ok);
    if (s_rdy) begin
      if (fl) begin
        mq.delete();
        next_id = 0;
      end else begin
        for (int c = 0; c < 2; c++) if (s_wv[c]) begin
          idx = find_id(s_wid[c]);
          if (idx >= 0) begin
            n = mq[idx]; n.done = 1'b1; n.val = s_wval[c]; n.tgt = s_wtgt[c]; mq[idx] = n;
          end
        end
        if (commit) void'(mq.pop_front());
        if (iss_ok) begin
          n.id = 4'(next_id); n.ty = s_ty; n.rd = s_rd; n.pc = s_pc; n.pt = s_pt;
          n.done = model_prep(s_ty); n.val = model_value(s_ty, s_pc, s_imm); n.tgt = '0;
          mq.push_back(n);
          next_id = (next_id + 1) % DEPTH;
        end
      end
    end
  endtask

  task automatic do_reset();
    idle_stim();
    rdy = 1'b1; issue_valid = 1'b0; wb_valid = '0; q_id1 = '0; q_id2 = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_rob_full", {31'd0, rob_full}, 32'd0);
    check("rst_issue_rob_id", {28'd0, issue_rob_id}, 32'd0);
    check("rst_head_rob_id", {28'd0, head_rob_id}, 32'd0);
    check("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_q_ready1", {31'd0, q_ready1}, 32'd0);
    mq.delete(); sb.delete(); next_id = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_cycle(input int wb_pct);
    int sel;
    logic [6:0] types [10];
    types = '{TY_ALU, TY_ALU, TY_ALU, TY_S_TYPE, TY_LUI, TY_AUIPC, TY_JAL, TY_JALR, TY_B_TYPE, TY_B_TYPE};
    idle_stim();
    s_rdy = ($urandom_range(0, 9) != 0);
    if ($urandom_range(0, 2) != 0)
      set_issue(types[$urandom_range(0, 9)], 5'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom));
    for (int c = 0; c < 2; c++) if ($urandom_range(0, 99) < wb_pct) begin
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) set_wb(c, mq[$urandom_range(0, mq.size() - 1)].id, $urandom, $urandom);
      else set_wb(c, 4'($urandom), $urandom, $urandom);
    end
    for (int p = 0; p < 2; p++) begin
      sel = $urandom_range(0, 2);
      s_q[p] = (sel == 0) ? s_wid[$urandom_range(0, 1)] : (sel == 1) ? 4'(next_id) : 4'($urandom);
    end
    applyStimulus();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++; failures++;
        $display("[TB] FAIL commit_missing: got no commit expected id %0d at cycle %0d", sb[0].id, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (commit_valid) begin
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          checks++; failures++;
          $display("[TB] FAIL commit_unexpected: got commit id %0d expected none (cycle %0d)", commit_rob_id, cyc);
        end else begin
          e = sb.pop_front();
          check("commit_rob_id", {28'd0, commit_rob_id}, {28'd0, e.id});
          check("commit_rd", {27'd0, commit_rd}, {27'd0, e.rd});
          check("commit_value", commit_value, e.val);
          check("commit_wr", {31'd0, commit_wr}, {31'd0, e.wr});
          check("commit_flush", {31'd0, flush}, {31'd0, e.fl});
          if (e.fl) check("flush_pc", flush_pc, e.fpc);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    idle_stim();
    rdy = 1'b1; issue_valid = 1'b0; issue_type = '0; issue_rd = '0; issue_pc = '0; issue_imm = '0;
    issue_pred_taken = 1'b0; wb_valid = '0; wb_rob_id = '0; wb_value = '0; wb_target = '0;
    q_id1 = '0; q_id2 = '0;
    @(negedge clk);
    do_reset();

    // Fill to full, then one ignored issue; tail wraps back to 0.
    for (int i = 0; i < 17; i++) begin
      idle_stim(); set_issue(TY_ALU, 5'(i + 1), 32'(i * 4), 32'd0, 1'b0); applyStimulus();
    end
    idle_stim(); applyStimulus();

    // Out-of-order completion 2,0,1 then dual write-backs.
    idle_stim(); set_wb(0, 4'd2, 32'h222, 32'd0); applyStimulus();
    idle_stim(); set_wb(0, 4'd0, 32'h100, 32'd0); applyStimulus();
    idle_stim(); set_wb(1, 4'd1, 32'h111, 32'd0); applyStimulus();
    idle_stim(); set_wb(0, 4'd3, 32'h11, 32'd0); set_wb(1, 4'd3, 32'h22, 32'd0); applyStimulus();
    idle_stim(); set_wb(0, 4'd4, 32'h44, 32'd0); set_wb(1, 4'd5, 32'h55, 32'd0); s_q[0] = 4'd3; applyStimulus();
    idle_stim(); s_q[0] = 4'd4; s_q[1] = 4'd5; applyStimulus();
    repeat (3) begin idle_stim(); applyStimulus(); end

    // Reset with five live entries.
    do_reset();
    for (int i = 0; i < 5; i++) begin idle_stim(); set_issue(TY_ALU, 5'd3, 32'h40, 32'd0, 1'b0); applyStimulus(); end
    do_reset();

    // Mispredicted branch; issue in the flush cycle is dropped.
    idle_stim(); set_issue(TY_B_TYPE, 5'd0, 32'h100, 32'h0, 1'b0); applyStimulus();
    idle_stim(); set_wb(0, 4'd0, 32'h1, 32'h80); applyStimulus();
    idle_stim(); set_issue(TY_LUI, 5'd7, 32'h200, 32'h5000, 1'b0); applyStimulus();
    idle_stim(); applyStimulus();

    // Same-cycle visibility of a write-back on channel 1.
    for (int i = 0; i < 6; i++) begin idle_stim(); set_issue(TY_ALU, 5'd9, 32'h300, 32'd0, 1'b0); applyStimulus(); end
    idle_stim(); set_wb(1, 4'd5, 32'h7, 32'd0); s_q[0] = 4'd5; applyStimulus();
    idle_stim(); s_q[0] = 4'd5; applyStimulus();

    for (int i = 0; i < 2400; i++) random_cycle((i / 400) % 2 == 0 ? 40 : 8);
    repeat (40) begin idle_stim(); applyStimulus(); end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
